// File: rtl/sum_display_driver.sv
// ---------------------------------------------------------------------------
// sum_display_driver
//
// Shows the 5-bit result of a 4-bit adder ({cout, s}, 0..31) on a
// multiplexed 4-digit common-anode 7-segment display. The display can be
// decimal (two digits, 0..31) or hexadecimal (two digits, 00..1F). A leading
// zero on digit 1 is blanked, and digits 2 and 3 are always dark. Each digit
// slot lasts REFRESH_DIV clocks. All anodes are held off for the first
// BLANK_CYC clocks of every slot so the previous digit's segments do not
// ghost onto the next digit.
//
// Parameters
//   REFRESH_DIV : clocks per digit slot (>= 2)
//   BLANK_CYC   : anode-off guard clocks at the start of each slot
//                 (0 <= BLANK_CYC < REFRESH_DIV)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   s        in   [3:0] adder sum bits
//   cout     in   adder carry-out
//   load     in   capture strobe for s, cout and hex_mode
//   hex_mode in   1 = hexadecimal display, 0 = decimal display
//   seg      out  [6:0] active-low cathodes {g,f,e,d,c,b,a}, registered
//   an       out  [3:0] active-low anodes, an[0] = rightmost digit, registered
//   cout_led out  captured carry, active-high, registered
// ---------------------------------------------------------------------------
module sum_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s,
    input  logic       cout,
    input  logic       load,
    input  logic       hex_mode,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       cout_led
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        DIG0,
        DIG1,
        DIG2,
        DIG3
    } scan_t;

    logic [4:0]    value;   // captured {cout, s}
    logic          mode;    // captured hex_mode
    logic [PW-1:0] presc;   // position within the current digit slot
    scan_t         state;   // digit slot being driven

    logic       tick;
    logic       guard;
    logic [1:0] tens;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [6:0] digit_seg;
    logic [3:0] digit_an;

    // Standard active-low hex font, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign tick  = (presc == PW'(REFRESH_DIV - 1));
    assign guard = (presc < PW'(BLANK_CYC));

    // Digit values and the pattern for the slot currently being scanned.
    // The result is registered below, so the pins see it one clock later.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave a value unassigned and infer a latch.
        tens      = 2'd0;
        d0        = 4'd0;
        d1        = 4'd0;
        digit_seg = SEG_BLANK;
        digit_an  = AN_OFF;

        // value is at most 31, so the tens digit is found by range compares
        // instead of a divider.
        if (value >= 5'd30)      tens = 2'd3;
        else if (value >= 5'd20) tens = 2'd2;
        else if (value >= 5'd10) tens = 2'd1;

        if (mode) begin
            d0 = value[3:0];
            d1 = {3'b000, value[4]};
        end else begin
            d0 = 4'(value - 5'(tens) * 5'd10);
            d1 = {2'b00, tens};
        end

        case (state)
            DIG0: begin
                digit_seg = hex7(d0);
                digit_an  = 4'b1110;
            end
            DIG1: begin
                digit_seg = (d1 == 4'd0) ? SEG_BLANK : hex7(d1);
                digit_an  = 4'b1101;
            end
            DIG2: begin
                digit_seg = SEG_BLANK;
                digit_an  = 4'b1011;
            end
            default: begin
                digit_seg = SEG_BLANK;
                digit_an  = 4'b0111;
            end
        endcase

        // Anti-ghosting guard at the head of every slot.
        if (guard) digit_an = AN_OFF;
    end

    // Capture registers, prescaler, scan FSM and registered outputs.
    // Reset wins over a simultaneous load, so that capture is discarded.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // right-hand side reads the value from before this edge.
        if (reset) begin
            value    <= 5'd0;
            mode     <= 1'b0;
            presc    <= '0;
            state    <= DIG0;
            seg      <= SEG_BLANK;
            an       <= AN_OFF;
            cout_led <= 1'b0;
        end else begin
            if (load) begin
                value <= {cout, s};
                mode  <= hex_mode;
            end

            if (tick) begin
                presc <= '0;
                case (state)
                    DIG0:    state <= DIG1;
                    DIG1:    state <= DIG2;
                    DIG2:    state <= DIG3;
                    default: state <= DIG0;
                endcase
            end else begin
                presc <= presc + 1'b1;
            end

            seg      <= digit_seg;
            an       <= digit_an;
            cout_led <= value[4];
        end
    end

endmodule

// File: tb/tb_sum_display_driver.sv
// ---------------------------------------------------------------------------
// tb_sum_display_driver
//
// Bench for sum_display_driver with REFRESH_DIV=4, BLANK_CYC=1.
// A behavioural model counts clocks since reset release and works out the
// expected display from the captured number with plain arithmetic (mod/div).
// One compare process checks the DUT against it one time unit after every
// rising edge. Directed sections pin the model with hand-computed literals.
// A randomized phase then applies loads and resets at random times.
// ---------------------------------------------------------------------------
module tb_sum_display_driver;

    localparam int RD = 4;
    localparam int BC = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] s = 4'd0;
    logic       cout = 1'b0;
    logic       load = 1'b0;
    logic       hex_mode = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       cout_led;

    int n_vec = 0;
    int n_err = 0;

    sum_display_driver #(
        .REFRESH_DIV(RD),
        .BLANK_CYC  (BC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s       (s),
        .cout    (cout),
        .load    (load),
        .hex_mode(hex_mode),
        .seg     (seg),
        .an      (an),
        .cout_led(cout_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] font(input int d);
        case (d)
            0: font = 7'b1000000;   1: font = 7'b1111001;
            2: font = 7'b0100100;   3: font = 7'b0110000;
            4: font = 7'b0011001;   5: font = 7'b0010010;
            6: font = 7'b0000010;   7: font = 7'b1111000;
            8: font = 7'b0000000;   9: font = 7'b0010000;
            10: font = 7'b0001000;  11: font = 7'b0000011;
            12: font = 7'b1000110;  13: font = 7'b0100001;
            14: font = 7'b0000110;  default: font = 7'b0001110;
        endcase
    endfunction

    // Clock n after release: slot = (n / RD) % 4, position in slot = n % RD.
    function automatic logic [3:0] model_an(input int n);
        int slot;
        slot = (n / RD) % 4;
        if ((n % RD) < BC) return 4'b1111;
        return ~(4'b0001 << slot);
    endfunction

    function automatic logic [6:0] model_seg(input int n, input int v, input bit hex);
        int slot, base, lo, hi;
        slot = (n / RD) % 4;
        base = hex ? 16 : 10;
        lo   = v % base;
        hi   = v / base;
        if (slot == 0) return font(lo);
        if (slot == 1 && hi != 0) return font(hi);
        return 7'b1111111;
    endfunction

    int         m_cnt = 0;
    int         m_v = 0;
    bit         m_hex = 1'b0;
    logic [6:0] exp_seg = 7'b1111111;
    logic [3:0] exp_an = 4'b1111;
    logic       exp_led = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt   <= 0;
            m_v     <= 0;
            m_hex   <= 1'b0;
            exp_seg <= 7'b1111111;
            exp_an  <= 4'b1111;
            exp_led <= 1'b0;
        end else begin
            exp_an  <= model_an(m_cnt);
            exp_seg <= model_seg(m_cnt, m_v, m_hex);
            exp_led <= (m_v >= 16);
            if (load) begin
                m_v   <= int'({cout, s});
                m_hex <= hex_mode;
            end
            m_cnt <= (m_cnt + 1) % (4 * RD);
        end
    end

    // Single compare process; seg is only meaningful while a digit is lit
    // or while reset holds it blank.
    always begin
        @(posedge clk);
        #1;
        check("model_an", 32'(an), 32'(exp_an));
        check("model_led", 32'(cout_led), 32'(exp_led));
        if (exp_an != 4'b1111 || reset)
            check("model_seg", 32'(seg), 32'(exp_seg));
    end

    // ---------------- directed helpers ----------------
    task automatic step_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step_sample();
            if (an == target) found = 1'b1;
        end
        if (!found) check({name, "_timeout"}, 32'(an), 32'(target));
    endtask

    task automatic do_load(input logic [3:0] sv, input logic cv, input logic hv);
        @(negedge clk);
        s = sv; cout = cv; hex_mode = hv; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int lo_cnt[4];
        int off_cnt;
        int multi;
        logic [3:0] seq_an[6];
        logic [6:0] seq_seg[6];

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_seg", 32'(seg), 32'(7'b1111111));
        check("reset_an", 32'(an), 32'(4'b1111));
        check("reset_led", 32'(cout_led), 32'(1'b0));

        // Release with no load: guard, three lit cycles of "0", guard, DIG1.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step_sample();
            seq_an[i]  = an;
            seq_seg[i] = seg;
        end
        check("rel_an0", 32'(seq_an[0]), 32'(4'b1111));
        check("rel_an1", 32'(seq_an[1]), 32'(4'b1110));
        check("rel_an3", 32'(seq_an[3]), 32'(4'b1110));
        check("rel_an4", 32'(seq_an[4]), 32'(4'b1111));
        check("rel_an5", 32'(seq_an[5]), 32'(4'b1101));
        check("rel_seg1", 32'(seq_seg[1]), 32'(7'b1000000));
        check("rel_seg5", 32'(seq_seg[5]), 32'(7'b1111111));

        // V=31 decimal: "31", carry lit.
        do_load(4'b1111, 1'b1, 1'b0);
        wait_an(4'b1110, "d31_dig0");
        check("d31_seg0", 32'(seg), 32'(7'b1111001));
        check("d31_led", 32'(cout_led), 32'(1'b1));
        wait_an(4'b1101, "d31_dig1");
        check("d31_seg1", 32'(seg), 32'(7'b0110000));

        // V=31 hex: "1F".
        do_load(4'b1111, 1'b1, 1'b1);
        wait_an(4'b1110, "h1f_dig0");
        check("h1f_seg0", 32'(seg), 32'(7'b0001110));
        wait_an(4'b1101, "h1f_dig1");
        check("h1f_seg1", 32'(seg), 32'(7'b1111001));

        // V=8 decimal: "8", leading zero blanked, upper digits dark.
        do_load(4'b1000, 1'b0, 1'b0);
        wait_an(4'b1110, "d8_dig0");
        check("d8_seg0", 32'(seg), 32'(7'b0000000));
        check("d8_led", 32'(cout_led), 32'(1'b0));
        wait_an(4'b1101, "d8_dig1");
        check("d8_seg1", 32'(seg), 32'(7'b1111111));
        wait_an(4'b1011, "d8_dig2");
        check("d8_seg2", 32'(seg), 32'(7'b1111111));
        wait_an(4'b0111, "d8_dig3");
        check("d8_seg3", 32'(seg), 32'(7'b1111111));

        // Reset and load together: capture discarded.
        @(negedge clk);
        s = 4'b1010; cout = 1'b0; hex_mode = 1'b0; load = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; load = 1'b0;
        wait_an(4'b1110, "rl_dig0");
        check("rl_seg0", 32'(seg), 32'(7'b1000000));
        check("rl_led", 32'(cout_led), 32'(1'b0));
        wait_an(4'b1101, "rl_dig1");
        check("rl_seg1", 32'(seg), 32'(7'b1111111));

        // Full 16-cycle scan: 3 lit cycles per digit, 4 guard cycles.
        off_cnt = 0; multi = 0;
        for (int k = 0; k < 4; k++) lo_cnt[k] = 0;
        for (int i = 0; i < 16; i++) begin
            step_sample();
            if (an == 4'b1111) off_cnt++;
            if ($countones(~an) > 1) multi++;
            for (int k = 0; k < 4; k++) if (!an[k]) lo_cnt[k]++;
        end
        for (int k = 0; k < 4; k++) check($sformatf("scan_low%0d", k), 32'(lo_cnt[k]), 32'd3);
        check("scan_off", 32'(off_cnt), 32'd4);
        check("scan_multi", 32'(multi), 32'd0);

        // Randomized loads (including mid-slot) and occasional mid-slot resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            s        = 4'($urandom);
            cout     = 1'($urandom);
            hex_mode = 1'($urandom);
            load     = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        reset = 1'b0; load = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
